// File: rtl/udiv_seq_16by8.sv
// Sequential unsigned restoring divider (DW-bit dividend / YW-bit divisor) with valid/ready handshakes.
// Define UDIV_APPROX_EN to drop the low APPROX_BITS dividend bits and shorten the iteration count.
module udiv_seq_16by8 #(
  parameter int DW          = 16,
  parameter int YW          = 8,
  parameter int APPROX_BITS = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] z,
  input  logic [YW-1:0] y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] q,
  output logic [YW-1:0] r,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW + 1);
  localparam int RW = YW + 1;
`ifdef UDIV_APPROX_EN
  localparam int SH = APPROX_BITS;
`else
  // The exact build always divides the full dividend.
  localparam int SH = APPROX_BITS - APPROX_BITS;
`endif
  localparam int            NIT   = DW - SH;
  localparam logic [CW-1:0] NIT_C = CW'(NIT);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q;
  logic [RW-1:0] rem_q;
  logic [DW-1:0] quo_q;
  logic [YW-1:0] y_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] q_q;
  logic [YW-1:0] r_q;
  logic          dbz_q;
  logic          in_ready_q;
  logic          out_valid_q;

  logic [RW:0]   shifted;
  logic          ge;
  logic [RW-1:0] rem_d;
  logic [DW-1:0] quo_d;

  // One restoring step: shift the MSB of the quotient register into the remainder, trial-subtract.
  always_comb begin
    shifted = {rem_q, quo_q[DW-1]};
    ge      = (shifted >= {2'b00, y_q});
    rem_d   = ge ? RW'(shifted - {2'b00, y_q}) : shifted[RW-1:0];
    quo_d   = {quo_q[DW-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      q_q         <= '0;
      r_q         <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            y_q        <= y;
            in_ready_q <= 1'b0;
            if (y != '0) begin
              rem_q   <= '0;
              // Low SH bits are cleared so exactly NIT dividend bits are shifted through.
              quo_q   <= (z >> SH) << SH;
              cnt_q   <= NIT_C;
              dbz_q   <= 1'b0;
              state_q <= CALC;
            end else begin
              q_q         <= '1;
              r_q         <= z[YW-1:0];
              dbz_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            q_q         <= quo_d << SH;
            r_q         <= rem_d[YW-1:0];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_udiv_seq_16by8.sv
// Self-checking bench for udiv_seq_16by8: vector table plus hand sequences, results checked via a scoreboard queue.
// Honors UDIV_APPROX_EN with the design's default APPROX_BITS.
module tb_udiv_seq_16by8;

  localparam int DW = 16;
  localparam int YW = 8;
  localparam int AB = 2;
`ifdef UDIV_APPROX_EN
  localparam int NIT = DW - AB;
`else
  localparam int NIT = DW;
`endif
  localparam int LAT_MAX = 100;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
  } exp_t;

  typedef struct {
    logic [15:0] z;
    logic [7:0]  y;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] z;
  logic [YW-1:0] y;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] q;
  logic [YW-1:0] r;
  logic          div_by_zero;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t tbl[8];

  always #5 clk = ~clk;

  udiv_seq_16by8 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .z          (z),
    .y          (y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .q          (q),
    .r          (r),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] zz, input logic [7:0] yy);
    exp_t        e;
    logic [15:0] zh;
    zh = zz;
    if (yy == 8'd0) begin
      e.q   = 16'hFFFF;
      e.r   = zz[7:0];
      e.dbz = 1'b1;
    end else begin
`ifdef UDIV_APPROX_EN
      zh    = zz >> AB;
      e.q   = 16'((zh / {8'd0, yy}) << AB);
      e.r   = 8'(zh % {8'd0, yy});
`else
      e.q   = zh / {8'd0, yy};
      e.r   = 8'(zh % {8'd0, yy});
`endif
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard: a result is taken off the queue whenever a handshake is about to complete.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn: q=%0d r=%0d dbz=%0d (exp q=%0d r=%0d dbz=%0d)", q, r, div_by_zero, e.q, e.r, e.dbz);
        chk("q", 32'(q), 32'(e.q));
        chk("r", 32'(r), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      end
    end
  end

  task automatic run_op(input logic [15:0] zz, input logic [7:0] yy, input exp_t e);
    int lat;
    @(negedge clk);
    z        = zz;
    y        = yy;
    in_valid = 1'b1;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    z        = 16'($urandom);
    y        = 8'($urandom);
    lat      = 0;
    while (!out_valid && lat < LAT_MAX) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), (yy == 8'd0) ? 32'd0 : 32'(NIT));
    if (out_ready) begin
      @(posedge clk);
      #1;
      chk("in_ready_after_accept", 32'(in_ready), 32'd1);
      chk("out_valid_after_accept", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    z         = '0;
    y         = '0;

`ifdef UDIV_APPROX_EN
    tbl[0] = '{16'd1003,  8'd7,   16'd140,   8'd5,    1'b0};
    tbl[1] = '{16'd3,     8'd2,   16'd0,     8'd0,    1'b0};
    tbl[2] = '{16'd65535, 8'd1,   16'd65532, 8'd0,    1'b0};
    tbl[3] = '{16'd65535, 8'd255, 16'd256,   8'd63,   1'b0};
    tbl[4] = '{16'h1234,  8'd0,   16'hFFFF,  8'h34,   1'b1};
    tbl[5] = '{16'd10,    8'd3,   16'd0,     8'd2,    1'b0};
    tbl[6] = '{16'd500,   8'd9,   16'd52,    8'd8,    1'b0};
    tbl[7] = '{16'd0,     8'd9,   16'd0,     8'd0,    1'b0};
`else
    tbl[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,    1'b0};
    tbl[1] = '{16'd65535, 8'd1,   16'd65535, 8'd0,    1'b0};
    tbl[2] = '{16'd65535, 8'd255, 16'd257,   8'd0,    1'b0};
    tbl[3] = '{16'h1234,  8'd0,   16'hFFFF,  8'h34,   1'b1};
    tbl[4] = '{16'd10,    8'd3,   16'd3,     8'd1,    1'b0};
    tbl[5] = '{16'd500,   8'd9,   16'd55,    8'd5,    1'b0};
    tbl[6] = '{16'd5,     8'd200, 16'd0,     8'd5,    1'b0};
    tbl[7] = '{16'd0,     8'd9,   16'd0,     8'd0,    1'b0};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      e.q   = tbl[i].q;
      e.r   = tbl[i].r;
      e.dbz = tbl[i].dbz;
      run_op(tbl[i].z, tbl[i].y, e);
    end

    for (int i = 0; i < 6; i++) begin
      logic [15:0] rz;
      logic [7:0]  ry;
      rz = 16'($urandom);
      ry = 8'($urandom_range(0, 255));
      run_op(rz, ry, model(rz, ry));
    end

    // Backpressure: result must stay put and new operands must be refused.
    out_ready = 1'b0;
    e = model(16'd500, 8'd9);
    run_op(16'd500, 8'd9, e);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = (i % 3 == 0);
      z        = 16'($urandom);
      y        = 8'($urandom);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_q", 32'(q), 32'(e.q));
      chk("hold_r", 32'(r), 32'(e.r));
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release_in_ready", 32'(in_ready), 32'd1);
    chk("hold_release_out_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of CALC discards the operation.
    @(negedge clk);
    z        = 16'd40000;
    y        = 8'd13;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_r", 32'(r), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'd40000, 8'd13, model(16'd40000, 8'd13));

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
